// File: rtl/load_store_unit_if.sv
// Word-addressed data-memory bus: request/ready handshake with byte enables.
// The LSU is the master; the request and its fields stay constant until ready is seen.
interface load_store_unit_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ready, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ready, bus_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store stage: IDLE -> ACCESS -> DONE, 3 cycles strobe-to-commit with a zero-wait slave.
// Stalls the core while ACCESS waits on bus_ready (no timeout); bad accesses raise err, never reach the bus.
module load_store_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        done,
    output logic        err,
    load_store_unit_if.master bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state;
    state_t      state_nxt;

    logic        strobe;
    logic        legal;
    logic        aligned;
    logic        accept;
    logic        reject;
    logic [3:0]  be_nxt;
    logic [31:0] wdata_nxt;

    logic        req_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        uns_q;

    // funct3[1:0] is the size (byte/half/word), funct3[2] the unsigned flag for loads
    always_comb begin
        strobe = mem_read | mem_write;
        legal  = 1'b0;
        if (mem_read && !mem_write) begin
            legal = (funct3[1:0] != 2'b11) && !(funct3[2] && funct3[1]);
        end else if (mem_write && !mem_read) begin
            legal = !funct3[2] && (funct3[1:0] != 2'b11);
        end

        case (funct3[1:0])
            2'b01:   aligned = !addr[0];
            2'b10:   aligned = (addr[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase

        case (funct3[1:0])
            2'b00: begin
                be_nxt    = 4'b0001 << addr[1:0];
                wdata_nxt = {4{wdata[7:0]}};
            end
            2'b01: begin
                be_nxt    = 4'b0011 << addr[1:0];
                wdata_nxt = {2{wdata[15:0]}};
            end
            default: begin
                be_nxt    = 4'b1111;
                wdata_nxt = wdata;
            end
        endcase

        accept = strobe && legal && aligned;
        reject = strobe && !(legal && aligned);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    stall     = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                stall = 1'b1;
                if (bus.bus_ready) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    function automatic logic [31:0] load_data(input logic [31:0] w, input logic [1:0] off,
                                              input logic [1:0] sz, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   load_data = uns ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   load_data = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: load_data = w;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            off_q   <= 2'b00;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            rdata   <= 32'h0;
            err     <= 1'b0;
        end else begin
            err <= (state == IDLE) && reject;
            if (state == IDLE && reject) begin
                rdata <= 32'h0;
            end
            if (state == IDLE && accept) begin
                req_q   <= 1'b1;
                we_q    <= mem_write;
                addr_q  <= {addr[31:2], 2'b00};
                be_q    <= be_nxt;
                wdata_q <= wdata_nxt;
                off_q   <= addr[1:0];
                size_q  <= funct3[1:0];
                uns_q   <= funct3[2];
            end else if (state == ACCESS && bus.bus_ready) begin
                // Fields stay latched after completion; only the request drops.
                req_q <= 1'b0;
                if (!we_q) begin
                    rdata <= load_data(bus.bus_rdata, off_q, size_q, uns_q);
                end
            end
        end
    end

    assign bus.bus_req   = req_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_be    = be_q;
    assign bus.bus_wdata = wdata_q;

endmodule
